id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  Decode-to-Execute pipeline register of the 5-stage RISC-V core. Captures decoded control,
//  register-file read data, PC values, register addresses and the sign-extended immediate
//  from the Decode stage, and presents them to the Execute stage one cycle later.
//  Supports hazard-unit stall (hold) and flush (bubble insertion) with a per-entry valid bit.
// PARAMETERS
//  WIDTH       32  datapath width (RD1/RD2/PC/PCPlus4/ImmExt)
//  REG_ADDR_W  5   register-file address width (Rs1/Rs2/Rd)
//  ALU_CTRL_W  3   ALUControl width
//  CNT_W       16  bubble-counter width (used only with BUBBLE_CNT_EN)
// PORTS
//  clk           in   1           core clock, all state updates on rising edge
//  rst_n         in   1           synchronous reset, active low
//  stall_E       in   1           hold current E contents (hazard unit)
//  flush_E       in   1           load a bubble instead of D inputs (hazard unit)
//  valid_D       in   1           D-stage holds a real instruction
//  RegWriteD     in   1           control: register write enable
//  ResultSrcD    in   2           control: writeback select
//  MemWriteD     in   1           control: data-memory write
//  JumpD         in   1           control: JAL/JALR
//  BranchD       in   1           control: conditional branch
//  ALUSrcD       in   1           control: ALU B operand = immediate
//  ALUControlD   in   ALU_CTRL_W  control: ALU operation
//  RD1D, RD2D    in   WIDTH       register-file read data
//  PCD, PCPlus4D in   WIDTH       instruction PC and PC+4
//  ImmExtD       in   WIDTH       immediate from the immediate extender
//  Rs1D,Rs2D,RdD in   REG_ADDR_W  source/destination register addresses
//  valid_E, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
//  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE   out  same widths as D inputs
//  bubble_cnt    out  CNT_W       bubbles inserted (present only with BUBBLE_CNT_EN)
// BEHAVIOUR
//  - All outputs are registered; latency D->E is exactly 1 cycle; no combinational D->E path.
//  - Reset (rst_n==0 at rising edge): every output cleared to 0, incl. valid_E and
//    bubble_cnt. Reset overrides stall_E and flush_E; reset mid-stall discards the held entry.
//  - Priority per edge: reset > flush_E > stall_E > normal load.
//  - Normal (flush_E=0, stall_E=0): every E output <= matching D input; valid_E <= valid_D.
//  - Stall (stall_E=1, flush_E=0): every E output holds its value; D inputs ignored.
//  - Flush (flush_E=1, regardless of stall_E): bubble loaded: valid_E, RegWriteE, MemWriteE,
//    JumpE, BranchE <= 0; ResultSrcE, ALUSrcE, ALUControlE <= 0; RD1E, RD2E, PCE,
//    PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE <= 0 (Rs/Rd zero keeps the forwarding unit inert).
//  - Normal load with valid_D=0: control outputs with side effects (RegWriteE, MemWriteE,
//    JumpE, BranchE) are forced to 0; data fields load normally; valid_E <= 0.
//  - Control is plain state: the register keeps no FSM; the entry has two states, VALID
//    (valid_E=1) and BUBBLE (valid_E=0), transitioning only per the rules above.
// CONFIGURATION
//  BUBBLE_CNT_EN defined: bubble_cnt port present; increments by 1 on every edge where
//    rst_n=1 and flush_E=1 (stall_E irrelevant); saturates at 2^CNT_W-1, no wrap.
//  BUBBLE_CNT_EN undefined: bubble_cnt port and counter logic absent; all other
//    behaviour identical.
// TESTING
//  1 rst_n=0 one edge with all D inputs 1s -> all E outputs 0, valid_E=0, bubble_cnt=0.
//  2 Load: valid_D=1, RegWriteD=1, ImmExtD=32'hFFFF_F800, RdD=5 -> next edge ImmExtE=
//    32'hFFFF_F800, RdE=5, RegWriteE=1, valid_E=1; no output changes before that edge.
//  3 Stall: stall_E=1 for 3 edges while D inputs change (PCD=0x100,0x104,0x108) ->
//    E outputs hold previous PCE=0x0FC throughout; release -> PCE=0x108 next edge.
//  4 Flush with stall_E=1 simultaneously, MemWriteD=1, Rs1D=7 -> MemWriteE=0, Rs1E=0,
//    valid_E=0; with BUBBLE_CNT_EN bubble_cnt increments 0->1.
//  5 valid_D=0 with RegWriteD=1, MemWriteD=1, RD1D=0x55 -> RegWriteE=0, MemWriteE=0,
//    RD1E=0x55, valid_E=0.
//  6 BUBBLE_CNT_EN, CNT_W=4: 20 consecutive flushes -> bubble_cnt reaches 15 and holds;
//    rst_n=0 mid-stall -> bubble_cnt=0 and E cleared next edge.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-Execute pipeline register: one registered entry with stall (hold) and flush (bubble).
// Optional bubble counter enabled by defining BUBBLE_CNT_EN.
module id_ex_pipeline_reg #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_E,
  input  logic                  flush_E,
  input  logic                  valid_D,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [ALU_CTRL_W-1:0] ALUControlD,
  input  logic [WIDTH-1:0]      RD1D,
  input  logic [WIDTH-1:0]      RD2D,
  input  logic [WIDTH-1:0]      PCD,
  input  logic [WIDTH-1:0]      PCPlus4D,
  input  logic [WIDTH-1:0]      ImmExtD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic                  valid_E,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [WIDTH-1:0]      RD1E,
  output logic [WIDTH-1:0]      RD2E,
  output logic [WIDTH-1:0]      PCE,
  output logic [WIDTH-1:0]      PCPlus4E,
  output logic [WIDTH-1:0]      ImmExtE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE
`ifdef BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  if (CNT_W < 1 || WIDTH < 1 || REG_ADDR_W < 1 || ALU_CTRL_W < 1) begin : g_bad_param
    $error("id_ex_pipeline_reg: widths must be >= 1");
  end

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]      rd1;
    logic [WIDTH-1:0]      rd2;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc_plus4;
    logic [WIDTH-1:0]      imm_ext;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  id_ex_t d_in, e_nxt, e_q;

  // Side-effecting controls of a non-instruction must never reach Execute; data still flows.
  always_comb begin
    d_in            = '0;
    d_in.valid      = valid_D;
    d_in.reg_write  = RegWriteD & valid_D;
    d_in.result_src = ResultSrcD;
    d_in.mem_write  = MemWriteD & valid_D;
    d_in.jump       = JumpD & valid_D;
    d_in.branch     = BranchD & valid_D;
    d_in.alu_src    = ALUSrcD;
    d_in.alu_ctrl   = ALUControlD;
    d_in.rd1        = RD1D;
    d_in.rd2        = RD2D;
    d_in.pc         = PCD;
    d_in.pc_plus4   = PCPlus4D;
    d_in.imm_ext    = ImmExtD;
    d_in.rs1        = Rs1D;
    d_in.rs2        = Rs2D;
    d_in.rd         = RdD;
  end

  // Flush beats stall; an all-zero bubble also zeroes Rs/Rd so forwarding never matches.
  always_comb begin
    e_nxt = e_q;
    if (flush_E)       e_nxt = '0;
    else if (!stall_E) e_nxt = d_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_nxt;
  end

  assign valid_E     = e_q.valid;
  assign RegWriteE   = e_q.reg_write;
  assign ResultSrcE  = e_q.result_src;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign ALUControlE = e_q.alu_ctrl;
  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign PCE         = e_q.pc;
  assign PCPlus4E    = e_q.pc_plus4;
  assign ImmExtE     = e_q.imm_ext;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;

`ifdef BUBBLE_CNT_EN
  // Saturating count of inserted bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n)                         bubble_cnt <= '0;
    else if (flush_E && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized scoreboard bench for id_ex_pipeline_reg (bubble counter checked when BUBBLE_CNT_EN).
module tb_id_ex_pipeline_reg;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } ent_t;

  typedef struct {
    ent_t ent;
    int   cnt;
  } exp_t;

  logic clk, rst_n, stall_E, flush_E;
  logic valid_D, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic valid_E, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0] Rs1E, Rs2E, RdE;
`ifdef BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  id_ex_pipeline_reg #(.WIDTH(32), .REG_ADDR_W(5), .ALU_CTRL_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_E(stall_E), .flush_E(flush_E), .valid_D(valid_D),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .valid_E(valid_E), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
`ifdef BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: what Execute should hold, and how many bubbles were inserted.
  ent_t m_e   = '0;
  int   m_cnt = 0;

  function automatic ent_t rand_ent();
    ent_t e;
    e.valid = 1'($urandom); e.reg_write = 1'($urandom); e.result_src = 2'($urandom);
    e.mem_write = 1'($urandom); e.jump = 1'($urandom); e.branch = 1'($urandom);
    e.alu_src = 1'($urandom); e.alu_ctrl = 3'($urandom);
    e.rd1 = $urandom; e.rd2 = $urandom; e.pc = $urandom; e.pc4 = $urandom; e.imm = $urandom;
    e.rs1 = 5'($urandom); e.rs2 = 5'($urandom); e.rd = 5'($urandom);
    return e;
  endfunction

  task automatic apply(input logic rst, input logic st, input logic fl, input ent_t d);
    exp_t x;
    rst_n = rst; stall_E = st; flush_E = fl;
    valid_D = d.valid; RegWriteD = d.reg_write; ResultSrcD = d.result_src;
    MemWriteD = d.mem_write; JumpD = d.jump; BranchD = d.branch; ALUSrcD = d.alu_src;
    ALUControlD = d.alu_ctrl; RD1D = d.rd1; RD2D = d.rd2; PCD = d.pc; PCPlus4D = d.pc4;
    ImmExtD = d.imm; Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
    @(posedge clk);
    if (!rst) begin
      m_e = '0; m_cnt = 0;
    end else if (fl) begin
      m_e = '0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!st) begin
      m_e = d;
      if (!d.valid) begin
        m_e.reg_write = 1'b0; m_e.mem_write = 1'b0; m_e.jump = 1'b0; m_e.branch = 1'b0;
      end
    end
    x.ent = m_e; x.cnt = m_cnt;
    sb.push_back(x);
    #1;
  endtask

  // Monitor: output is presented every cycle, so each negedge retires one expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      ent_t act;
      x = sb.pop_front();
      act = {valid_E, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
             RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};
      n_vec++;
      if (act !== x.ent) begin
        n_err++;
        $display("FAIL e_entry t=%0t act=%h exp=%h", $time, act, x.ent);
      end
`ifdef BUBBLE_CNT_EN
      n_vec++;
      if (int'(bubble_cnt) != x.cnt) begin
        n_err++;
        $display("FAIL bubble_cnt t=%0t act=%0d exp=%0d", $time, bubble_cnt, x.cnt);
      end
`endif
    end
  end

  initial begin
    ent_t d;
    // 1: reset with every D input high
    apply(1'b0, 1'b0, 1'b0, '1);
    apply(1'b0, 1'b1, 1'b1, '1);
    // 2: simple load
    d = '0; d.valid = 1'b1; d.reg_write = 1'b1; d.imm = 32'hFFFF_F800; d.rd = 5'd5;
    apply(1'b1, 1'b0, 1'b0, d);
    // 3: load PC 0x0FC, stall three edges while D moves, then release
    d = rand_ent(); d.valid = 1'b1; d.pc = 32'h0FC;
    apply(1'b1, 1'b0, 1'b0, d);
    d.pc = 32'h100; apply(1'b1, 1'b1, 1'b0, d);
    d.pc = 32'h104; apply(1'b1, 1'b1, 1'b0, d);
    d.pc = 32'h108; apply(1'b1, 1'b1, 1'b0, d);
    apply(1'b1, 1'b0, 1'b0, d);
    // 4: flush together with stall
    d = rand_ent(); d.valid = 1'b1; d.mem_write = 1'b1; d.rs1 = 5'd7;
    apply(1'b1, 1'b1, 1'b1, d);
    // 5: non-instruction with side-effecting controls set
    d = rand_ent(); d.valid = 1'b0; d.reg_write = 1'b1; d.mem_write = 1'b1;
    d.jump = 1'b1; d.branch = 1'b1; d.rd1 = 32'h55;
    apply(1'b1, 1'b0, 1'b0, d);
    // 6: counter saturation, then reset during a stall
    for (int i = 0; i < 20; i++) apply(1'b1, 1'($urandom), 1'b1, rand_ent());
    d = rand_ent(); d.valid = 1'b1;
    apply(1'b1, 1'b0, 1'b0, d);
    apply(1'b1, 1'b1, 1'b0, rand_ent());
    apply(1'b0, 1'b1, 1'b0, rand_ent());
    apply(1'b1, 1'b1, 1'b0, rand_ent());
    // Random mix, reset rare, flush/stall moderate
    for (int i = 0; i < 400; i++) begin
      logic r, s, f;
      r = ($urandom_range(0, 29) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 5) == 0);
      apply(r, s, f, rand_ent());
    end
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
